// File: rtl/simple_pattern_gen.sv
// Burst pattern generator: IDLE/RUN/DONE FSM emits len beats on a valid/ready port.
// Define PATTERN_GEN_LFSR_EN to turn mode 11 into an LFSR step instead of an increment.
module simple_pattern_gen #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [LEN_W-1:0] len,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  typedef struct packed {
    logic [1:0]       mode;
    logic [LEN_W-1:0] len;
  } cfg_t;

  state_t           r_state, w_state_nxt;
  cfg_t             r_cfg, w_cfg_nxt;
  logic [WIDTH-1:0] r_pat, w_pat_nxt, w_seed, w_adv;
  logic [LEN_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_beat, w_last;

  // Seed alternates 0/1 starting with bit 0 = 0 (8'hAA for WIDTH=8).
  genvar g;
  generate
    for (g = 0; g < WIDTH; g++) begin : g_seed
      assign w_seed[g] = 1'(g % 2);
    end
  endgenerate

  always_comb begin
    w_adv = r_pat;
    case (r_cfg.mode)
      2'b00: w_adv = r_pat;
      2'b01: w_adv = {r_pat[WIDTH-2:0], r_pat[WIDTH-1]};
      2'b10: w_adv = ~r_pat;
      default: begin
`ifdef PATTERN_GEN_LFSR_EN
        w_adv = {r_pat[WIDTH-2:0], r_pat[WIDTH-1] ^ r_pat[WIDTH-2]};
`else
        w_adv = r_pat + WIDTH'(1);
`endif
      end
    endcase
  end

  assign w_beat = (r_state == S_RUN) && out_ready;
  // Counter never exceeds len, so it cannot wrap even at len = 2^LEN_W-1.
  assign w_last = (LEN_W'(r_cnt + LEN_W'(1)) == r_cfg.len);

  always_comb begin
    w_state_nxt = r_state;
    w_cfg_nxt   = r_cfg;
    w_pat_nxt   = r_pat;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_pat_nxt   = w_seed;
          w_cnt_nxt   = '0;
          w_cfg_nxt   = '{mode: mode, len: len};
          w_state_nxt = (len != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (w_beat) begin
          w_pat_nxt = w_adv;
          w_cnt_nxt = LEN_W'(r_cnt + LEN_W'(1));
          if (w_last) w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cfg   <= '0;
      r_pat   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cfg   <= w_cfg_nxt;
      r_pat   <= w_pat_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign out_valid = (r_state == S_RUN);
  assign out_data  = r_pat;
  assign busy      = (r_state == S_RUN) || (r_state == S_DONE);
  assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_simple_pattern_gen.sv
// Directed bench for simple_pattern_gen (WIDTH=8, LEN_W=4); observes {out_valid,busy,done,out_data}.
module tb_simple_pattern_gen;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [1:0] mode;
  logic [3:0] len;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_err = 0;

  simple_pattern_gen #(.WIDTH(8), .LEN_W(4)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .mode     (mode),
    .len      (len),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  wire [10:0] obs = {out_valid, busy, done, out_data};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; mode = 2'b00; len = 4'd0; out_ready = 1'b0;
    #2;
    n_cmp++;
    if (obs !== 11'h000) begin n_err++; $display("FAIL reset_state: got %h expected %h", obs, 11'h000); end
    tick(); tick();
    reset_n = 1'b1;
    tick(); tick();
    n_cmp++;
    if (obs !== 11'h000) begin n_err++; $display("FAIL reset_idle: got %h expected %h", obs, 11'h000); end
  endtask

  task automatic test_rotate();
    logic [7:0] exp [0:2];
    exp[0] = 8'hAA; exp[1] = 8'h55; exp[2] = 8'hAA;
    start = 1'b1; mode = 2'b01; len = 4'd3; out_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (obs !== {3'b110, exp[i]}) begin
        n_err++; $display("FAIL rotate_beat%0d: got %h expected %h", i, obs, {3'b110, exp[i]});
      end
      tick();
    end
    n_cmp++;
    if ({out_valid, busy, done} !== 3'b011) begin
      n_err++; $display("FAIL rotate_done: got %b expected %b", {out_valid, busy, done}, 3'b011);
    end
    tick();
    n_cmp++;
    if ({out_valid, busy, done} !== 3'b000) begin
      n_err++; $display("FAIL rotate_idle: got %b expected %b", {out_valid, busy, done}, 3'b000);
    end
  endtask

  task automatic test_increment();
    logic [7:0] exp [0:2];
`ifdef PATTERN_GEN_LFSR_EN
    exp[0] = 8'hAA; exp[1] = 8'h55; exp[2] = 8'hAB;
`else
    exp[0] = 8'hAA; exp[1] = 8'hAB; exp[2] = 8'hAC;
`endif
    start = 1'b1; mode = 2'b11; len = 4'd3; out_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (obs !== {3'b110, exp[i]}) begin
        n_err++; $display("FAIL incr_beat%0d: got %h expected %h", i, obs, {3'b110, exp[i]});
      end
      tick();
    end
    n_cmp++;
    if ({out_valid, busy, done} !== 3'b011) begin
      n_err++; $display("FAIL incr_done: got %b expected %b", {out_valid, busy, done}, 3'b011);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int n_done = 0;
    start = 1'b1; mode = 2'b10; len = 4'd2; out_ready = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (obs !== {3'b110, 8'hAA}) begin
        n_err++; $display("FAIL bp_hold%0d: got %h expected %h", i, obs, {3'b110, 8'hAA});
      end
      tick();
    end
    out_ready = 1'b1;
    n_cmp++;
    if (obs !== {3'b110, 8'hAA}) begin n_err++; $display("FAIL bp_beat0: got %h expected %h", obs, {3'b110, 8'hAA}); end
    tick();
    n_cmp++;
    if (obs !== {3'b110, 8'h55}) begin n_err++; $display("FAIL bp_beat1: got %h expected %h", obs, {3'b110, 8'h55}); end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done) n_done++;
    end
    n_cmp++;
    if (n_done !== 1) begin n_err++; $display("FAIL bp_done_count: got %0d expected %0d", n_done, 1); end
  endtask

  task automatic test_zero_len();
    start = 1'b1; mode = 2'b01; len = 4'd0; out_ready = 1'b1;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL zl_pre: got %b expected %b", out_valid, 1'b0); end
    tick();
    start = 1'b0;
    n_cmp++;
    if ({out_valid, busy, done} !== 3'b011) begin
      n_err++; $display("FAIL zl_done: got %b expected %b", {out_valid, busy, done}, 3'b011);
    end
    tick();
    n_cmp++;
    if ({out_valid, busy, done} !== 3'b000) begin
      n_err++; $display("FAIL zl_after: got %b expected %b", {out_valid, busy, done}, 3'b000);
    end
  endtask

  task automatic test_reset_midburst();
    int n_done = 0;
    start = 1'b1; mode = 2'b01; len = 4'd5; out_ready = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n_cmp++;
    if (obs !== {3'b110, 8'h55}) begin n_err++; $display("FAIL rm_beat1: got %h expected %h", obs, {3'b110, 8'h55}); end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if (obs !== 11'h000) begin n_err++; $display("FAIL rm_async: got %h expected %h", obs, 11'h000); end
    tick(); tick();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done || out_valid) n_done++;
    end
    n_cmp++;
    if (n_done !== 0) begin n_err++; $display("FAIL rm_quiet: got %0d expected %0d", n_done, 0); end
    start = 1'b1; mode = 2'b01; len = 4'd2;
    tick();
    start = 1'b0;
    n_cmp++;
    if (obs !== {3'b110, 8'hAA}) begin n_err++; $display("FAIL rm_restart0: got %h expected %h", obs, {3'b110, 8'hAA}); end
    tick();
    n_cmp++;
    if (obs !== {3'b110, 8'h55}) begin n_err++; $display("FAIL rm_restart1: got %h expected %h", obs, {3'b110, 8'h55}); end
    tick(); tick();
  endtask

  task automatic test_start_ignored();
    logic [7:0] exp [0:2];
    exp[0] = 8'hAA; exp[1] = 8'h55; exp[2] = 8'hAA;
    start = 1'b1; mode = 2'b01; len = 4'd3; out_ready = 1'b1;
    tick();
    start = 1'b1; mode = 2'b10; len = 4'd1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (obs !== {3'b110, exp[i]}) begin
        n_err++; $display("FAIL si_beat%0d: got %h expected %h", i, obs, {3'b110, exp[i]});
      end
      tick();
    end
    n_cmp++;
    if ({out_valid, busy, done} !== 3'b011) begin
      n_err++; $display("FAIL si_done: got %b expected %b", {out_valid, busy, done}, 3'b011);
    end
    start = 1'b0;
    tick();
    n_cmp++;
    if ({out_valid, busy, done} !== 3'b000) begin
      n_err++; $display("FAIL si_idle: got %b expected %b", {out_valid, busy, done}, 3'b000);
    end
  endtask

  task automatic test_back_to_back();
    start = 1'b1; mode = 2'b00; len = 4'd2; out_ready = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if (obs !== {3'b110, 8'hAA}) begin n_err++; $display("FAIL b2b_hold0: got %h expected %h", obs, {3'b110, 8'hAA}); end
    tick();
    n_cmp++;
    if (obs !== {3'b110, 8'hAA}) begin n_err++; $display("FAIL b2b_hold1: got %h expected %h", obs, {3'b110, 8'hAA}); end
    tick();
    tick();
    start = 1'b1; mode = 2'b01; len = 4'd2;
    n_cmp++;
    if ({out_valid, busy, done} !== 3'b000) begin
      n_err++; $display("FAIL b2b_idle: got %b expected %b", {out_valid, busy, done}, 3'b000);
    end
    tick();
    start = 1'b0;
    n_cmp++;
    if (obs !== {3'b110, 8'hAA}) begin n_err++; $display("FAIL b2b_new0: got %h expected %h", obs, {3'b110, 8'hAA}); end
    tick();
    n_cmp++;
    if (obs !== {3'b110, 8'h55}) begin n_err++; $display("FAIL b2b_new1: got %h expected %h", obs, {3'b110, 8'h55}); end
    tick();
    n_cmp++;
    if ({out_valid, busy, done} !== 3'b011) begin
      n_err++; $display("FAIL b2b_done: got %b expected %b", {out_valid, busy, done}, 3'b011);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_rotate();
    test_increment();
    test_backpressure();
    test_zero_len();
    test_reset_midburst();
    test_start_ignored();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
